// File: rtl/uart_rx_ext.sv
// uart_rx_ext: parametrised UART receiver with parity/framing flags, break recovery and show-ahead FIFO
//   i_CLK, i_RSTN         clock, async active-low reset (released synchronously)
//   i_Rx_Serial           serial line, idle high
//   o_Rx_Byte/_Parity_Err/_Frame_Err  FIFO head word and its flags
//   o_Rx_Valid, i_Rx_Ready            head handshake, pop on valid & ready
//   o_Overrun, i_Clear_Err            sticky dropped-word flag and its clear pulse
//   o_Fifo_Count, o_Busy              occupancy, receiver not idle
module uart_rx_ext #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          i_CLK,
    input  logic                          i_RSTN,
    input  logic                          i_Rx_Serial,
    output logic [7:0]                    o_Rx_Byte,
    output logic                          o_Rx_Parity_Err,
    output logic                          o_Rx_Frame_Err,
    output logic                          o_Rx_Valid,
    input  logic                          i_Rx_Ready,
    output logic                          o_Overrun,
    input  logic                          i_Clear_Err,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
    output logic                          o_Busy
);
    localparam int HALF = (CLKS_PER_BIT - 1) / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    localparam int EW   = DATA_BITS + 2;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

    logic [1:0] rst_q;
    logic       rst_n;
    always_ff @(posedge i_CLK or negedge i_RSTN)
        if (!i_RSTN) rst_q <= 2'b00;
        else         rst_q <= {rst_q[0], 1'b1};
    assign rst_n = rst_q[1];

    logic [1:0] rx_q;
    logic       rx_s;
    always_ff @(posedge i_CLK or negedge rst_n)
        if (!rst_n) rx_q <= 2'b11;
        else        rx_q <= {rx_q[0], i_Rx_Serial};
    assign rx_s = rx_q[1];

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2:0]             idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   perr_q, perr_d, ferr_q, ferr_d;
    logic                   smp, push;

    always_ff @(posedge i_CLK or negedge rst_n)
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end

    assign smp = cnt_q == CW'(CLKS_PER_BIT - 1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                idx_d  = '0;
                perr_d = 1'b0;
                ferr_d = 1'b0;
                if (!rx_s) state_d = S_START;
            end
            // mid-start-bit recheck rejects glitches shorter than half a bit
            S_START: if (cnt_q == CW'(HALF)) begin
                cnt_d   = '0;
                state_d = rx_s ? S_IDLE : S_DATA;
            end
            // LSB arrives first, so shifting right leaves it at bit 0 once full
            S_DATA: if (smp) begin
                cnt_d   = '0;
                shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                idx_d   = idx_q + 3'd1;
                if (idx_q == 3'(DATA_BITS - 1)) begin
                    idx_d   = '0;
                    state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: if (smp) begin
                cnt_d   = '0;
                perr_d  = ^shift_q ^ rx_s ^ (PARITY == 1);
                state_d = S_STOP;
            end
            S_STOP: if (smp) begin
                cnt_d  = '0;
                idx_d  = idx_q + 3'd1;
                ferr_d = ferr_q | !rx_s;
                if (idx_q == 3'(STOP_BITS - 1)) begin
                    idx_d   = '0;
                    state_d = (ferr_q | !rx_s) ? S_BREAK : S_IDLE;
                end
            end
            // a held-low line must not be re-read as a fresh start bit
            S_BREAK: begin
                cnt_d = '0;
                if (rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_Busy = state_q != S_IDLE;
        push   = (state_q == S_STOP) && smp && (idx_q == 3'(STOP_BITS - 1));
    end

    logic [EW-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_q, rd_q;
    logic [CNTW-1:0] fcnt_q;
    logic            ovr_q, full, pop, wr;
    logic [EW-1:0]   head;

    assign full = fcnt_q == CNTW'(FIFO_DEPTH);
    assign pop  = o_Rx_Valid & i_Rx_Ready;
    assign wr   = push & (!full | pop);

    always_ff @(posedge i_CLK or negedge rst_n)
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            fcnt_q <= '0;
            ovr_q  <= 1'b0;
        end else begin
            if (wr) begin
                mem_q[wr_q] <= {ferr_d, perr_q, shift_q};
                wr_q        <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
            fcnt_q <= fcnt_q + CNTW'(wr) - CNTW'(pop);
            // a new overrun outranks a simultaneous clear
            ovr_q  <= (push & full & !pop) | (ovr_q & !i_Clear_Err);
        end

    assign head            = mem_q[rd_q];
    assign o_Rx_Byte       = 8'(head[DATA_BITS-1:0]);
    assign o_Rx_Parity_Err = head[DATA_BITS];
    assign o_Rx_Frame_Err  = head[DATA_BITS+1];
    assign o_Rx_Valid      = fcnt_q != '0;
    assign o_Fifo_Count    = fcnt_q;
    assign o_Overrun       = ovr_q;
endmodule

// File: tb/tb_uart_rx_ext.sv
// tb_uart_rx_ext: scoreboard bench for uart_rx_ext, an 8N1 instance (a) and a 7E2 instance (b)
module tb_uart_rx_ext;
    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    logic rx_a = 1'b1, rx_b = 1'b1;
    logic fix_rdy_a = 1'b1, fix_rdy_b = 1'b1, rand_rdy = 1'b0;
    logic rnd_a = 1'b1, rnd_b = 1'b1;
    logic rdy_a, rdy_b;
    logic clr_a = 1'b0, clr_b = 1'b0;
    logic [7:0] byte_a, byte_b;
    logic pe_a, fe_a, v_a, ov_a, busy_a;
    logic pe_b, fe_b, v_b, ov_b, busy_b;
    logic [2:0] cnt_a, cnt_b;

    int vectors = 0, miscompares = 0, edge_cnt = 0, rise_a = -1;
    logic v_a_prev = 1'b0;
    logic exp_ovr_a = 1'b0;
    logic [9:0] expq_a[$];
    logic [9:0] expq_b[$];

    assign rdy_a = rand_rdy ? rnd_a : fix_rdy_a;
    assign rdy_b = rand_rdy ? rnd_b : fix_rdy_b;

    uart_rx_ext #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
        .i_CLK(clk), .i_RSTN(rstn), .i_Rx_Serial(rx_a), .o_Rx_Byte(byte_a),
        .o_Rx_Parity_Err(pe_a), .o_Rx_Frame_Err(fe_a), .o_Rx_Valid(v_a), .i_Rx_Ready(rdy_a),
        .o_Overrun(ov_a), .i_Clear_Err(clr_a), .o_Fifo_Count(cnt_a), .o_Busy(busy_a));

    uart_rx_ext #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_b (
        .i_CLK(clk), .i_RSTN(rstn), .i_Rx_Serial(rx_b), .o_Rx_Byte(byte_b),
        .o_Rx_Parity_Err(pe_b), .o_Rx_Frame_Err(fe_b), .o_Rx_Valid(v_b), .i_Rx_Ready(rdy_b),
        .o_Overrun(ov_b), .i_Clear_Err(clr_b), .o_Fifo_Count(cnt_b), .o_Busy(busy_b));

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt++;
    always @(posedge clk) begin
        #1;
        rnd_a = 1'($urandom);
        rnd_b = 1'($urandom);
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired vectors=%0d", vectors);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin : mon_a
        logic [9:0] e;
        if (v_a && !v_a_prev) rise_a = edge_cnt;
        v_a_prev = v_a;
        if (v_a && rdy_a) begin
            if (expq_a.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL a_unexpected got=%0h expected=none", {fe_a, pe_a, byte_a});
            end else begin
                e = expq_a.pop_front();
                check("a_word", {22'd0, fe_a, pe_a, byte_a}, {22'd0, e});
            end
        end
    end

    always @(negedge clk) begin : mon_b
        logic [9:0] e;
        if (v_b && rdy_b) begin
            if (expq_b.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL b_unexpected got=%0h expected=none", {fe_b, pe_b, byte_b});
            end else begin
                e = expq_b.pop_front();
                check("b_word", {22'd0, fe_b, pe_b, byte_b}, {22'd0, e});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // 8N1 frame; a consumer that never drains keeps at most 4 words, the rest are lost
    task automatic send_a(input logic [7:0] d);
        logic [9:0] bits;
        bits = {1'b1, d, 1'b0};
        if (!rand_rdy && !fix_rdy_a && expq_a.size() == 4) exp_ovr_a = 1'b1;
        else expq_a.push_back({2'b00, d});
        for (int i = 0; i < 10; i++) begin
            rx_a = bits[i];
            repeat (CPB) tick();
        end
        rx_a = 1'b1;
    endtask

    // 7E2 frame with caller-chosen parity and stop bits
    task automatic send_b(input logic [6:0] d, input logic pbit, input logic [1:0] stops);
        logic [10:0] bits;
        logic pe, fe;
        bits = {stops, pbit, d, 1'b0};
        pe = pbit != (^d);
        fe = stops != 2'b11;
        expq_b.push_back({fe, pe, 1'b0, d});
        for (int i = 0; i < 11; i++) begin
            rx_b = bits[i];
            repeat (CPB) tick();
        end
        rx_b = 1'b1;
        repeat (3) tick();
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((expq_a.size() != 0 || expq_b.size() != 0) && n < 3000) begin
            tick();
            n++;
        end
        repeat (4) tick();
        check({name, "_pending"}, expq_a.size() + expq_b.size(), 0);
        check({name, "_cnt_a"}, {29'd0, cnt_a}, 0);
        check({name, "_cnt_b"}, {29'd0, cnt_b}, 0);
    endtask

    initial begin
        int t0;
        #1 rstn = 1'b0;
        repeat (4) tick();
        check("rst_byte", {24'd0, byte_a}, 0);
        check("rst_flags", {28'd0, pe_a, fe_a, v_a, ov_a}, 0);
        check("rst_cnt", {29'd0, cnt_a}, 0);
        check("rst_busy", {31'd0, busy_a}, 0);
        rstn = 1'b1;
        repeat (5) tick();

        t0 = edge_cnt;
        send_a(8'hA5);
        repeat (4) tick();
        check("a5_latency", rise_a - t0, 155);
        drain("a5");

        send_b(7'h37, 1'b0, 2'b11);
        send_b(7'h37, 1'b1, 2'b11);
        drain("par37");

        expq_a.push_back({2'b10, 8'h00});
        rx_a = 1'b0;
        repeat (20 * CPB) tick();
        rx_a = 1'b1;
        repeat (5) tick();
        send_a(8'h5A);
        drain("break");

        rx_a = 1'b0;
        repeat (3) tick();
        rx_a = 1'b1;
        repeat (3) tick();
        check("glitch_busy_hi", {31'd0, busy_a}, 1);
        repeat (20) tick();
        check("glitch_busy_lo", {31'd0, busy_a}, 0);
        check("glitch_cnt", {29'd0, cnt_a}, 0);

        fix_rdy_a = 1'b0;
        for (int i = 1; i <= 5; i++) send_a(8'(i));
        repeat (4) tick();
        check("ovr_cnt", {29'd0, cnt_a}, 4);
        check("ovr_flag", {31'd0, ov_a}, {31'd0, exp_ovr_a});
        fix_rdy_a = 1'b1;
        drain("ovr");
        clr_a = 1'b1;
        @(negedge clk);
        check("clr_same_cycle", {31'd0, ov_a}, {31'd0, exp_ovr_a});
        tick();
        clr_a = 1'b0;
        exp_ovr_a = 1'b0;
        @(negedge clk);
        check("clr_next_cycle", {31'd0, ov_a}, {31'd0, exp_ovr_a});
        tick();

        fix_rdy_a = 1'b0;
        send_a(8'h77);
        repeat (2) tick();
        check("pre_rst_cnt", {29'd0, cnt_a}, 1);
        rx_a = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 4; i++) begin
            rx_a = i[0] ? 1'b0 : 1'b1;
            repeat (CPB) tick();
        end
        rx_a = 1'b0;
        repeat (CPB / 2) tick();
        #3 rstn = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, v_a}, 0);
        check("mid_rst_cnt", {29'd0, cnt_a}, 0);
        check("mid_rst_byte", {24'd0, byte_a}, 0);
        check("mid_rst_busy", {31'd0, busy_a}, 0);
        expq_a.delete();
        expq_b.delete();
        rx_a = 1'b1;
        repeat (3) tick();
        rstn = 1'b1;
        repeat (5) tick();
        fix_rdy_a = 1'b1;
        send_a(8'hC3);
        drain("post_rst");

        rand_rdy = 1'b1;
        fork
            for (int i = 0; i < 15; i++) begin
                send_a(8'($urandom));
                repeat ($urandom_range(0, 10)) tick();
            end
            for (int i = 0; i < 15; i++) begin
                send_b(7'($urandom), 1'($urandom),
                       ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11);
                repeat ($urandom_range(0, 10)) tick();
            end
        join
        drain("random");
        check("final_ovr_a", {31'd0, ov_a}, 0);
        check("final_ovr_b", {31'd0, ov_b}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
